irq_controller: RTL and testbench

Prioritised interrupt controller between the board's interrupt sources and the multicycle CPU's `EX_irq` / `INT_Vector` inputs. It synchronises up to `N_SRC` asynchronous request lines and latches their rising edges as pending. It applies a CPU-written mask and picks the highest-priority eligible source. It then holds `EX_irq` and a stable vector until the CPU acknowledges, and blocks further requests until the handler signals end-of-interrupt.

---
 rtl/irq_controller.sv | 141 ++++++++++++++
 tb/tb_irq_controller.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// Prioritised interrupt controller: synchronises async request lines, latches rising
// edges as pending, and hands the lowest-index unmasked source to the CPU with a frozen vector.
module irq_controller #(
    parameter int          N_SRC    = 4,
    parameter logic [31:0] VEC_BASE = 32'h0000_0040
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic [N_SRC-1:0] src_irq,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    input  logic             int_ack,
    input  logic             eoi,
    output logic             EX_irq,
    output logic [31:0]      INT_Vector,
    output logic [N_SRC-1:0] mask,
    output logic [N_SRC-1:0] pending,
    output logic [2:0]       active_id,
    output logic             in_service
);

    // state   | meaning
    // IDLE    | no request outstanding; waits for an eligible source
    // REQ     | EX_irq high, id/vector frozen until int_ack
    // SERVICE | handler running; no new request until eoi
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N_SRC-1:0]   sync1_q, sync2_q, prev_q;
    logic [N_SRC-1:0]   pending_q, pending_d;
    logic [N_SRC-1:0]   mask_q, mask_d;
    logic               ex_irq_q, ex_irq_d;
    logic [31:0]        vector_q, vector_d;
    logic [2:0]         active_id_q, active_id_d;

    logic [N_SRC-1:0]   edge_det;
    logic [N_SRC-1:0]   eligible;
    logic [N_SRC-1:0]   ack_clr;
    logic [2:0]         win_id;
    logic               ack_take;

    assign edge_det = sync2_q & ~prev_q;
    assign eligible = pending_q & mask_q;

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= src_irq;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Iterating downwards lets the lowest set index be the last (winning) assignment.
    always_comb begin
        win_id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_id = 3'(i);
            end
        end
    end

    assign ack_take = (state_q == ST_REQ) && int_ack;

    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            ack_clr[i] = ack_take && (3'(i) == active_id_q);
        end
    end

    // A new edge landing on the ack cycle wins over the clear.
    assign pending_d = (pending_q & ~ack_clr) | edge_det;
    assign mask_d    = mask_we ? mask_wdata : mask_q;

    always_comb begin
        state_d     = state_q;
        ex_irq_d    = ex_irq_q;
        vector_d    = vector_q;
        active_id_d = active_id_q;
        case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    state_d     = ST_REQ;
                    ex_irq_d    = 1'b1;
                    active_id_d = win_id;
                    vector_d    = VEC_BASE + {27'd0, win_id, 2'b00};
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    state_d  = ST_SERVICE;
                    ex_irq_d = 1'b0;
                end
            end
            ST_SERVICE: begin
                if (eoi) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                ex_irq_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            mask_q      <= '1;
            ex_irq_q    <= 1'b0;
            vector_q    <= '0;
            active_id_q <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            ex_irq_q    <= ex_irq_d;
            vector_q    <= vector_d;
            active_id_q <= active_id_d;
        end
    end

    assign EX_irq     = ex_irq_q;
    assign INT_Vector = vector_q;
    assign mask       = mask_q;
    assign pending    = pending_q;
    assign active_id  = active_id_q;
    assign in_service = (state_q == ST_SERVICE);

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: inputs driven and outputs sampled on the falling edge,
// expected values worked out by hand from the cycle timeline.
module tb_irq_controller;

    logic        clk;
    logic        Rst;
    logic [3:0]  src_irq;
    logic        mask_we;
    logic [3:0]  mask_wdata;
    logic        int_ack;
    logic        eoi;
    logic        EX_irq;
    logic [31:0] INT_Vector;
    logic [3:0]  mask;
    logic [3:0]  pending;
    logic [2:0]  active_id;
    logic        in_service;

    int checks   = 0;
    int failures = 0;

    irq_controller #(.N_SRC(4), .VEC_BASE(32'h0000_0040)) dut (
        .clk        (clk),
        .Rst        (Rst),
        .src_irq    (src_irq),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .int_ack    (int_ack),
        .eoi        (eoi),
        .EX_irq     (EX_irq),
        .INT_Vector (INT_Vector),
        .mask       (mask),
        .pending    (pending),
        .active_id  (active_id),
        .in_service (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        Rst        = 1'b0;
        src_irq    = 4'b0010;
        mask_we    = 1'b0;
        mask_wdata = 4'h0;
        int_ack    = 1'b0;
        eoi        = 1'b0;
        step(3);
        chk("rst_ex_irq",  32'(EX_irq),     32'h0);
        chk("rst_vector",  INT_Vector,      32'h0);
        chk("rst_mask",    32'(mask),       32'hF);
        chk("rst_pending", 32'(pending),    32'h0);
        chk("rst_in_svc",  32'(in_service), 32'h0);

        // src_irq[1] held through release: pending at 3rd edge, request at 4th
        Rst = 1'b1;
        step(3);
        chk("rel_pend",    32'(pending),    32'h2);
        chk("rel_ex_lo",   32'(EX_irq),     32'h0);
        step(1);
        chk("rel_ex_hi",   32'(EX_irq),     32'h1);
        chk("rel_vector",  INT_Vector,      32'h44);
        chk("rel_id",      32'(active_id),  32'h1);
        int_ack = 1'b1;
        step(1);
        int_ack = 1'b0;
        chk("ack1_ex",     32'(EX_irq),     32'h0);
        chk("ack1_svc",    32'(in_service), 32'h1);
        chk("ack1_pend",   32'(pending),    32'h0);
        eoi = 1'b1;
        step(1);
        eoi = 1'b0;
        chk("eoi1_svc",    32'(in_service), 32'h0);

        // priority: sources 2 and 3 together
        src_irq = 4'b1100;
        step(4);
        chk("pri_ex",      32'(EX_irq),     32'h1);
        chk("pri_vector",  INT_Vector,      32'h48);
        chk("pri_id",      32'(active_id),  32'h2);
        chk("pri_pend",    32'(pending),    32'hC);
        int_ack = 1'b1;
        step(1);
        int_ack = 1'b0;
        chk("pri_ack_pend", 32'(pending),   32'h8);
        eoi = 1'b1;
        step(1);
        eoi = 1'b0;
        chk("gap_ex",      32'(EX_irq),     32'h0);
        step(1);
        chk("pri2_ex",     32'(EX_irq),     32'h1);
        chk("pri2_vector", INT_Vector,      32'h4C);
        chk("pri2_pend",   32'(pending),    32'h8);

        // frozen vector: source 0 arrives while source 3 is requested
        src_irq = 4'b1101;
        step(4);
        chk("frz_vector",  INT_Vector,      32'h4C);
        chk("frz_id",      32'(active_id),  32'h3);
        chk("frz_pend",    32'(pending),    32'h9);
        src_irq = 4'b0000;
        int_ack = 1'b1;
        step(1);
        int_ack = 1'b0;
        chk("frz_ack_pend", 32'(pending),   32'h1);
        eoi = 1'b1;
        step(1);
        eoi = 1'b0;
        step(1);
        chk("src0_ex",     32'(EX_irq),     32'h1);
        chk("src0_vector", INT_Vector,      32'h40);
        int_ack = 1'b1;
        step(1);
        int_ack = 1'b0;
        eoi = 1'b1;
        step(1);
        eoi = 1'b0;

        // stray ack in IDLE
        int_ack = 1'b1;
        step(1);
        int_ack = 1'b0;
        chk("stray_ack_ex",  32'(EX_irq),     32'h0);
        chk("stray_ack_svc", 32'(in_service), 32'h0);

        // masking: pending latches but no request until unmasked
        mask_we    = 1'b1;
        mask_wdata = 4'b1110;
        step(1);
        mask_we = 1'b0;
        chk("mask_wr",     32'(mask),       32'hE);
        src_irq = 4'b0001;
        step(1);
        src_irq = 4'b0000;
        step(2);
        chk("mask_pend",   32'(pending),    32'h1);
        step(1);
        chk("mask_ex",     32'(EX_irq),     32'h0);
        mask_we    = 1'b1;
        mask_wdata = 4'hF;
        step(1);
        mask_we = 1'b0;
        chk("unmask_ex_lo", 32'(EX_irq),    32'h0);
        step(1);
        chk("unmask_ex",   32'(EX_irq),     32'h1);
        chk("unmask_vec",  INT_Vector,      32'h40);

        // stray eoi in REQ
        eoi = 1'b1;
        step(1);
        eoi = 1'b0;
        chk("stray_eoi_ex",  32'(EX_irq),     32'h1);
        chk("stray_eoi_svc", 32'(in_service), 32'h0);
        chk("stray_eoi_vec", INT_Vector,      32'h40);
        int_ack = 1'b1;
        step(1);
        int_ack = 1'b0;
        eoi = 1'b1;
        step(1);
        eoi = 1'b0;

        // collision: fresh edge on source 1 lands on its own ack cycle
        src_irq = 4'b0010;
        step(1);
        src_irq = 4'b0000;
        step(3);
        chk("col_ex",      32'(EX_irq),     32'h1);
        chk("col_vector",  INT_Vector,      32'h44);
        src_irq = 4'b0010;
        step(2);
        int_ack = 1'b1;
        step(1);
        int_ack = 1'b0;
        chk("col_pend",    32'(pending),    32'h2);
        chk("col_svc",     32'(in_service), 32'h1);
        eoi = 1'b1;
        step(1);
        eoi = 1'b0;
        step(1);
        chk("col_rereq",   32'(EX_irq),     32'h1);
        src_irq = 4'b0000;
        int_ack = 1'b1;
        step(1);
        int_ack = 1'b0;
        mask_we    = 1'b1;
        mask_wdata = 4'b0011;
        step(1);
        mask_we = 1'b0;
        chk("svc_mask",    32'(mask),       32'h3);
        chk("svc_in_svc",  32'(in_service), 32'h1);
        chk("svc_id",      32'(active_id),  32'h1);

        // asynchronous reset between edges while in SERVICE
        #2;
        Rst = 1'b0;
        #1;
        chk("arst_svc",    32'(in_service), 32'h0);
        chk("arst_ex",     32'(EX_irq),     32'h0);
        chk("arst_vector", INT_Vector,      32'h0);
        chk("arst_id",     32'(active_id),  32'h0);
        chk("arst_mask",   32'(mask),       32'hF);
        chk("arst_pend",   32'(pending),    32'h0);
        step(2);
        Rst = 1'b1;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
